// File: rtl/pld_pkg.sv
// Shared types and fuse-count helpers for the PLD fuse programmer.
// The helpers size the AND and OR fuse planes from the PLD dimensions.
package pld_pkg;

   localparam int CHK_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2
   } prog_state_e;

   function automatic int and_fuses(input int n);
      return (2 ** (n + 2)) * (n ** 2);
   endfunction

   function automatic int or_fuses(input int n, input int m);
      return m * (2 ** (2 * n));
   endfunction

endpackage

// File: rtl/pld_fuse_shadow_reg.sv
// Shadow register for an incoming fuse frame.
// Also keeps a running count of the ones in the frame, modulo 256.
module pld_fuse_shadow_reg
   import pld_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int IDX_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             wr_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] shadow_o,
   output logic [CHK_W-1:0] ones_o
);

   logic [WIDTH-1:0] shadow_q;
   logic [CHK_W-1:0] ones_q;

   // NOTE: the shadow is built from flops rather than RAM, so it can be cleared by the async reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         ones_q   <= '0;
      end else if (clr_i) begin
         shadow_q <= '0;
         ones_q   <= '0;
      end else if (wr_i) begin
         shadow_q[idx_i] <= bit_i;
         ones_q          <= ones_q + CHK_W'(bit_i);
      end
   end

   assign shadow_o = shadow_q;
   assign ones_o   = ones_q;

endmodule

// File: rtl/pld_fuse_programmer.sv
// Serial fuse-frame writer. It loads the payload into a shadow register and
// checks the trailing checksum. The live AND and OR fuse vectors change only on a matching checksum.
module pld_fuse_programmer
   import pld_pkg::*;
#(
   parameter  int NUM_PORTS_IN  = 1,
   parameter  int NUM_PORTS_OUT = 1,
   localparam int AND_FUSES     = and_fuses(NUM_PORTS_IN),
   localparam int OR_FUSES      = or_fuses(NUM_PORTS_IN, NUM_PORTS_OUT),
   localparam int TOTAL_FUSES   = AND_FUSES + OR_FUSES
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 cfg_bit_i,
   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   output logic [AND_FUSES-1:0] and_matrix_fuses_conf_o,
   output logic [OR_FUSES-1:0]  or_matrix_fuses_conf_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic                 configured_o
);

   localparam int TRL_IDX_W = $clog2(CHK_W);
   localparam int CNT_W     = ($clog2(TOTAL_FUSES) > TRL_IDX_W) ? $clog2(TOTAL_FUSES) : TRL_IDX_W;

   prog_state_e          state_q, state_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [CHK_W-2:0]     trailer_q, trailer_d;
   logic [AND_FUSES-1:0] and_q, and_d;
   logic [OR_FUSES-1:0]  or_q, or_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 configured_q, configured_d;

   logic                   sh_clr, sh_wr, accept;
   logic [TOTAL_FUSES-1:0] shadow;
   logic [CHK_W-1:0]       ones_cnt;

   assign cfg_ready_o = (state_q == LOAD) || (state_q == CHECK);
   assign accept      = cfg_valid_i && cfg_ready_o;

   pld_fuse_shadow_reg #(
      .WIDTH (TOTAL_FUSES),
      .IDX_W (CNT_W)
   ) u_shadow (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (sh_clr),
      .wr_i     (sh_wr),
      .idx_i    (bit_cnt_q),
      .bit_i    (cfg_bit_i),
      .shadow_o (shadow),
      .ones_o   (ones_cnt)
   );

   // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      trailer_d    = trailer_q;
      and_d        = and_q;
      or_d         = or_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      configured_d = configured_q;
      sh_clr       = 1'b0;
      sh_wr        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d   = LOAD;
               bit_cnt_d = '0;
               sh_clr    = 1'b1;
            end
         end
         LOAD: begin
            if (accept) begin
               sh_wr = 1'b1;
               if (bit_cnt_q == CNT_W'(TOTAL_FUSES - 1)) begin
                  state_d   = CHECK;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         CHECK: begin
            if (accept) begin
               if (bit_cnt_q == CNT_W'(CHK_W - 1)) begin
                  // The final trailer bit is compared straight from the input, so the commit happens on this edge.
                  if ({cfg_bit_i, trailer_q} == ones_cnt) begin
                     and_d        = shadow[AND_FUSES-1:0];
                     or_d         = shadow[TOTAL_FUSES-1:AND_FUSES];
                     done_d       = 1'b1;
                     configured_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
                  state_d   = IDLE;
                  bit_cnt_d = '0;
               end else begin
                  trailer_d[bit_cnt_q[TRL_IDX_W-1:0]] = cfg_bit_i;
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments, so every register samples its pre-edge inputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         trailer_q    <= '0;
         and_q        <= '0;
         or_q         <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         configured_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         trailer_q    <= trailer_d;
         and_q        <= and_d;
         or_q         <= or_d;
         done_q       <= done_d;
         err_q        <= err_d;
         configured_q <= configured_d;
      end
   end

   assign and_matrix_fuses_conf_o = and_q;
   assign or_matrix_fuses_conf_o  = or_q;
   assign busy_o                  = (state_q != IDLE);
   assign done_o                  = done_q;
   assign err_o                   = err_q;
   assign configured_o            = configured_q;

endmodule

// File: tb/tb_pld_fuse_programmer.sv
// Randomised, self-checking bench for pld_fuse_programmer with N=1 and M=1 (8 AND fuses, 4 OR fuses).
// Expected results come from a frame-level model: the checksum is the popcount of the payload, modulo 256.
module tb_pld_fuse_programmer;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       start_i = 1'b0;
   logic       cfg_bit_i = 1'b0;
   logic       cfg_valid_i = 1'b0;
   logic       cfg_ready_o;
   logic [7:0] and_matrix_fuses_conf_o;
   logic [3:0] or_matrix_fuses_conf_o;
   logic       busy_o, done_o, err_o, configured_o;

   int total = 0;
   int bad = 0;
   int acc_cnt = 0;

   // Frame-level reference state.
   logic [7:0] m_and = '0;
   logic [3:0] m_or = '0;
   logic       m_conf = 1'b0;

   pld_fuse_programmer #(
      .NUM_PORTS_IN  (1),
      .NUM_PORTS_OUT (1)
   ) dut (
      .clk_i                   (clk_i),
      .rst_i                   (rst_i),
      .start_i                 (start_i),
      .cfg_bit_i               (cfg_bit_i),
      .cfg_valid_i             (cfg_valid_i),
      .cfg_ready_o             (cfg_ready_o),
      .and_matrix_fuses_conf_o (and_matrix_fuses_conf_o),
      .or_matrix_fuses_conf_o  (or_matrix_fuses_conf_o),
      .busy_o                  (busy_o),
      .done_o                  (done_o),
      .err_o                   (err_o),
      .configured_o            (configured_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i)
      if (!rst_i && cfg_valid_i && cfg_ready_o) acc_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog sim_time=%0t required=finish_before_limit", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic drive_bit(input logic b, input bit st);
      int waited = 0;
      cfg_valid_i = 1'b1;
      cfg_bit_i   = b;
      start_i     = st;
      @(negedge clk_i);
      while (!cfg_ready_o) begin
         waited++;
         if (waited > 100) begin
            total++; bad++;
            $display("FAIL handshake_timeout ready=%0b required=1", cfg_ready_o);
            break;
         end
         @(negedge clk_i);
      end
      @(posedge clk_i); #1;
      cfg_valid_i = 1'b0;
      start_i     = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [3:0] o, input logic [7:0] t,
                            input bit gaps, input int start_at, input bit skip_start, input bit b2b);
      logic [19:0] fr;
      logic        exp_ok;
      int          acc0;
      fr = {t, o, a};
      if (!skip_start) begin
         start_i = 1'b1;
         @(posedge clk_i); #1;
         start_i = 1'b0;
      end
      acc0 = acc_cnt;
      @(negedge clk_i);
      total++;
      if (busy_o !== 1'b1) begin bad++; $display("FAIL frame_busy got=%0b want=1", busy_o); end
      total++;
      if (cfg_ready_o !== 1'b1) begin bad++; $display("FAIL frame_ready got=%0b want=1", cfg_ready_o); end
      @(posedge clk_i); #1;
      for (int k = 0; k < 20; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               cfg_valid_i = 1'b0;
               cfg_bit_i   = 1'($urandom);
               @(posedge clk_i); #1;
            end
         end
         drive_bit(fr[k], (k == start_at));
      end
      exp_ok = (8'($countones({o, a})) == t);
      if (exp_ok) begin
         m_and  = a;
         m_or   = o;
         m_conf = 1'b1;
      end
      if (b2b) start_i = 1'b1;
      @(negedge clk_i);
      total++;
      if (done_o !== exp_ok) begin bad++; $display("FAIL done_pulse got=%0b want=%0b", done_o, exp_ok); end
      total++;
      if (err_o !== !exp_ok) begin bad++; $display("FAIL err_pulse got=%0b want=%0b", err_o, !exp_ok); end
      total++;
      if (busy_o !== 1'b0) begin bad++; $display("FAIL busy_after got=%0b want=0", busy_o); end
      total++;
      if (and_matrix_fuses_conf_o !== m_and) begin bad++; $display("FAIL and_fuses got=%h want=%h", and_matrix_fuses_conf_o, m_and); end
      total++;
      if (or_matrix_fuses_conf_o !== m_or) begin bad++; $display("FAIL or_fuses got=%h want=%h", or_matrix_fuses_conf_o, m_or); end
      total++;
      if (configured_o !== m_conf) begin bad++; $display("FAIL configured got=%0b want=%0b", configured_o, m_conf); end
      total++;
      if (acc_cnt - acc0 != 20) begin bad++; $display("FAIL accepted_bits got=%0d want=20", acc_cnt - acc0); end
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (!b2b) begin
         @(negedge clk_i);
         total++;
         if ({done_o, err_o} !== 2'b00) begin bad++; $display("FAIL pulse_width done=%0b err=%0b want=00", done_o, err_o); end
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({and_matrix_fuses_conf_o, or_matrix_fuses_conf_o} !== 12'h000) begin
         bad++; $display("FAIL reset_fuses got=%h want=000", {and_matrix_fuses_conf_o, or_matrix_fuses_conf_o});
      end
      total++;
      if ({cfg_ready_o, busy_o, done_o, err_o, configured_o} !== 5'b0) begin
         bad++; $display("FAIL reset_flags got=%b want=00000", {cfg_ready_o, busy_o, done_o, err_o, configured_o});
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      total++;
      if ({cfg_ready_o, busy_o, configured_o} !== 3'b0) begin
         bad++; $display("FAIL idle_after_reset got=%b want=000", {cfg_ready_o, busy_o, configured_o});
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_good_frame();
      run_frame(8'hA5, 4'h3, 8'h06, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_bad_checksum();
      run_frame(8'hFF, 4'hF, 8'h00, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      int acc0;
      acc0 = acc_cnt;
      repeat (4) begin
         cfg_valid_i = 1'b1;
         cfg_bit_i   = 1'($urandom);
         @(negedge clk_i);
         total++;
         if (cfg_ready_o !== 1'b0) begin bad++; $display("FAIL ready_in_idle got=%0b want=0", cfg_ready_o); end
         @(posedge clk_i); #1;
      end
      // Start arrives together with a valid bit; that bit must not be taken.
      cfg_valid_i = 1'b1;
      cfg_bit_i   = 1'b1;
      start_i     = 1'b1;
      @(posedge clk_i); #1;
      start_i     = 1'b0;
      cfg_valid_i = 1'b0;
      total++;
      if (acc_cnt != acc0) begin bad++; $display("FAIL idle_bits_taken got=%0d want=0", acc_cnt - acc0); end
      run_frame(8'hA5, 4'h3, 8'h06, 1'b1, -1, 1'b1, 1'b0);
   endtask

   task automatic test_start_mid_load();
      run_frame(8'hFF, 4'hF, 8'h0C, 1'b0, 5, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      logic [19:0] fr;
      fr = {8'h06, 4'h3, 8'hA5};
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int k = 0; k < 15; k++) drive_bit(fr[k], 1'b0);
      #2 rst_i = 1'b1;
      #1;
      total++;
      if ({and_matrix_fuses_conf_o, or_matrix_fuses_conf_o} !== 12'h000) begin
         bad++; $display("FAIL async_rst_fuses got=%h want=000", {and_matrix_fuses_conf_o, or_matrix_fuses_conf_o});
      end
      total++;
      if ({configured_o, cfg_ready_o, busy_o} !== 3'b000) begin
         bad++; $display("FAIL async_rst_flags got=%b want=000", {configured_o, cfg_ready_o, busy_o});
      end
      m_and  = '0;
      m_or   = '0;
      m_conf = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      run_frame(8'h3C, 4'h5, 8'h06, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_frame(8'h81, 4'h8, 8'h03, 1'b0, -1, 1'b0, 1'b1);
      run_frame(8'h7E, 4'h6, 8'h08, 1'b1, -1, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      bit         prev_b2b = 1'b0;
      bit         b2b;
      logic [7:0] a, t;
      logic [3:0] o;
      for (int i = 0; i < 12; i++) begin
         a   = 8'($urandom);
         o   = 4'($urandom);
         t   = ($urandom_range(0, 3) != 0) ? 8'($countones({o, a})) : 8'($urandom);
         b2b = (i != 11) && ($urandom_range(0, 2) == 0);
         run_frame(a, o, t, 1'($urandom), -1, prev_b2b, b2b);
         prev_b2b = b2b;
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_backpressure();
      test_start_mid_load();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
